seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Consumes the 32-bit word chosen by the display-select stage and shows it as 8 hex digits.
- Scans one digit at a time at a prescaled rate and inserts anti-ghosting blank cycles.
- Snapshots the input word at each frame boundary, so a frame never shows a mix of old and new nibbles.

Parameters:
- DIV, 100000: clk cycles per digit slot; legal range DIV >= 2. Default gives 1 kHz per digit at 100 MHz.
- BLANK_CYCLES, 1: cycles at the start of each slot with all digits off; legal range 0 <= BLANK_CYCLES < DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data  in  32  word to display; data[3:0] is the rightmost digit (digit 0)
- blank_lz  in  1  1 = blank leading zero digits
- led  out  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}
- en  out  8  digit anodes, active-low; en[i] drives digit i
- frame_done  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - On assertion, all state clears immediately with no clock edge: cnt=0, idx=0, shadow=0, en=8'hFF, led=7'h7F, frame_done=0.
  - Assertion mid-scan blanks the display in the same instant.
  - The first frame after reset displays shadow=0.
- Prescaler cnt, width $clog2(DIV):
  - Counts 0..DIV-1, then wraps to 0.
  - tick = (cnt==DIV-1).
- Digit index idx, 3 bits:
  - On tick, idx <= idx+1; 7 wraps to 0.
- Snapshot:
  - On tick with idx==7, shadow <= data.
  - frame_done <= 1 on that same edge, so it is high for exactly the following cycle; otherwise 0.
  - frame_done period = 8*DIV cycles.
  - data changes at any other time have no visible effect until the next snapshot.
- Blanking of a digit:
  - Ghost blank: cnt < BLANK_CYCLES.
  - Leading-zero blank: blank_lz=1, idx>=1, and shadow nibbles idx..7 are all zero.
  - Digit 0 is never leading-zero blanked, so a zero value shows a single "0".
  - blank_lz is sampled every cycle; no snapshot.
- Outputs are registered, each clock:
  - If blanked: en <= 8'hFF, led <= 7'h7F.
  - Otherwise: en <= ~(8'b1 << idx), led <= seg(shadow[4*idx+3 : 4*idx]).
  - Outputs therefore lag cnt/idx by one cycle.
  - At most one en bit is low at any time.
- Segment code seg (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Arithmetic: all counters wrap modulo their range. No overflow flags.

Test Plan:
- Reset: run scanning, pull rst_n low between clock edges -> en=FF, led=7F, frame_done=0 immediately. Release -> first lit slot shows digit 0 = "0" (led=40, en=FE).
- Scan order (DIV=4, BLANK_CYCLES=1, blank_lz=0, data=32'h01234567), after the first frame_done:
  - Each 4-cycle slot shows 1 cycle of en=FF, then 3 cycles of the lit digit.
  - Lit sequence (en/led): FE/78, FD/02, FB/12, F7/19, EF/30, DF/24, BF/79, 7F/40.
- Hex glyphs: data=32'h89ABCDEF -> digits 0..7 show led 0E, 06, 21, 46, 03, 08, 10, 00.
- Leading-zero blanking with blank_lz=1:
  - data=32'h000000A5 -> only en[0] (led 12) and en[1] (led 08) ever go low.
  - data=0 -> only en[0] goes low, with led=40.
  - data=32'h80000000 -> all 8 digits lit.
- Snapshot integrity: change data from 32'h11111111 to 32'h22222222 while idx=3 -> remaining digits of the frame still show 79. The new value appears only after the next frame_done. frame_done spacing = 32 cycles at DIV=4.
- BLANK_CYCLES=0: en never reads FF between slots while blank_lz=0; each slot is a full 4 cycles lit.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// The 32-bit input word is shown as 8 hex digits, one digit lit at a time.
// Each digit gets a slot of DIV clock cycles. The first BLANK_CYCLES cycles
// of every slot keep all anodes off, so the previous digit does not ghost.
// The input word is copied into a shadow register once per frame. A frame
// therefore never mixes nibbles from two different words.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   data[31:0] in   word to display; data[3:0] is digit 0 (rightmost)
//   blank_lz   in   1 = blank leading zero digits (digit 0 always shown)
//   led[6:0]   out  segment cathodes, active-low, {g,f,e,d,c,b,a}
//   en[7:0]    out  digit anodes, active-low; en[i] drives digit i
//   frame_done out  one-cycle pulse after each new snapshot of data
//
// All outputs are registered. They lag the slot counter and the digit index
// by one cycle.

module seg7_scan_driver #(
    parameter int DIV          = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        blank_lz,
    output logic [6:0]  led,
    output logic [7:0]  en,
    output logic        frame_done
);

    localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       en_q, en_d;
    logic [6:0]       led_q, led_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             ghost_blank;
    logic             lz_blank;
    logic [7:0]       zero_from;   // zero_from[i]: shadow nibbles i..7 are all zero
    logic [3:0]       nibble;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        // The snapshot is taken as the scan wraps from digit 7 back to digit 0.
        frame_done_d = tick && (idx_q == 3'd7);
        shadow_d     = frame_done_d ? data : shadow_q;

        // Scan from the top nibble down, so that each digit can see whether
        // it and all digits above it are zero.
        zero_from    = '0;
        zero_from[7] = (shadow_q[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow_q[4*i +: 4] == 4'h0);
        end

        ghost_blank = (cnt_q < BLANK_C);
        lz_blank    = blank_lz && (idx_q != 3'd0) && zero_from[idx_q];
        nibble      = shadow_q[{idx_q, 2'b00} +: 4];

        en_d  = 8'hFF;
        led_d = 7'h7F;
        if (!(ghost_blank || lz_blank)) begin
            en_d  = ~(8'b1 << idx_q);
            led_d = seg(nibble);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 32'h0;
            en_q         <= 8'hFF;
            led_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            en_q         <= en_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign en         = en_q;
    assign led        = led_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        blank_lz;
    logic [6:0]  led0, led1;
    logic [7:0]  en0, en1;
    logic        fd0, fd1;

    int total = 0;
    int bad   = 0;

    // u0: one ghost-blank cycle per slot; u1: no ghost blanking.
    seg7_scan_driver #(.DIV(4), .BLANK_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data), .blank_lz(blank_lz),
        .led(led0), .en(en0), .frame_done(fd0)
    );

    seg7_scan_driver #(.DIV(4), .BLANK_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data), .blank_lz(blank_lz),
        .led(led1), .en(en1), .frame_done(fd1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        blz;
        logic [7:0]  mask;   // digits expected to light up
        logic [55:0] leds;   // {d7,...,d0} segment codes, 7 bits each
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for a frame_done sample on u0.
    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd0 && n < 40);
        total++;
        if (!fd0) begin
            bad++;
            $display("FAIL wait_fd: no frame_done within %0d cycles", n);
        end
    endtask

    // Check one full frame, starting just after a frame_done sample (k=0).
    // Sample k lies in slot (k-1)/4 at phase (k-1)%4.
    task automatic run_frame(input logic [55:0] leds, input logic [7:0] mask,
                             input logic chg, input logic [31:0] newd);
        int s, ph;
        logic [7:0] e_en0, e_en1;
        logic [6:0] e_led0, e_led1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            s  = (k - 1) / 4;
            ph = (k - 1) % 4;
            e_en1  = mask[s] ? ~(8'b1 << s) : 8'hFF;
            e_led1 = mask[s] ? leds[7*s +: 7] : 7'h7F;
            e_en0  = (ph < 1) ? 8'hFF : e_en1;
            e_led0 = (ph < 1) ? 7'h7F : e_led1;
            chk($sformatf("en0 k=%0d", k), en0, e_en0);
            chk($sformatf("led0 k=%0d", k), {1'b0, led0}, {1'b0, e_led0});
            chk($sformatf("en1 k=%0d", k), en1, e_en1);
            chk($sformatf("led1 k=%0d", k), {1'b0, led1}, {1'b0, e_led1});
            chk($sformatf("fd0 k=%0d", k), {7'b0, fd0}, {7'b0, (k == 32)});
            chk($sformatf("one_hot k=%0d", k), 8'($countones(~en0) <= 1), 8'd1);
            if (chg && k == 14) data = newd;
        end
    endtask

    initial begin
        vecs[0] = '{32'h01234567, 1'b0, 8'hFF,
                    {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
        vecs[1] = '{32'h89ABCDEF, 1'b0, 8'hFF,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[2] = '{32'h000000A5, 1'b1, 8'h03,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
        vecs[3] = '{32'h00000000, 1'b1, 8'h01,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{32'h80000000, 1'b1, 8'hFF,
                    {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{32'h00F00000, 1'b1, 8'h3F,
                    {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{32'h01234567, 1'b1, 8'h7F,
                    {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};

        rst_n    = 1'b0;
        data     = 32'h0;
        blank_lz = 1'b0;
        #12;
        chk("rst en0", en0, 8'hFF);
        chk("rst led0", {1'b0, led0}, 8'h7F);
        chk("rst fd0", {7'b0, fd0}, 8'h00);
        chk("rst en1", en1, 8'hFF);

        // Release at a negedge: the first frame starts like a post-snapshot
        // frame and shows shadow=0 on every digit.
        @(negedge clk);
        rst_n = 1'b1;
        run_frame({8{7'h40}}, 8'hFF, 1'b0, 32'h0);

        for (int i = 0; i < 7; i++) begin
            data = vecs[i].data;
            wait_fd();
            blank_lz = vecs[i].blz;
            run_frame(vecs[i].leds, vecs[i].mask, 1'b0, 32'h0);

            if (i == 0) begin
                // Now at the last lit cycle of digit 7; reset between edges.
                #2;
                rst_n = 1'b0;
                #1;
                chk("midrst en0", en0, 8'hFF);
                chk("midrst led0", {1'b0, led0}, 8'h7F);
                chk("midrst fd0", {7'b0, fd0}, 8'h00);
                chk("midrst en1", en1, 8'hFF);
                @(negedge clk);
                rst_n = 1'b1;
                run_frame({8{7'h40}}, 8'hFF, 1'b0, 32'h0);
            end
        end

        // Snapshot integrity: data changes during digit 3 of a frame.
        blank_lz = 1'b0;
        data = 32'h11111111;
        wait_fd();
        run_frame({8{7'h79}}, 8'hFF, 1'b1, 32'h22222222);
        run_frame({8{7'h24}}, 8'hFF, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
